// File: rtl/hi_lo_multiply_divide_unit.sv
// ============================================================================
// hi_lo_multiply_divide_unit
//
// Iterative multiply/divide unit that owns the architectural HI and LO
// registers. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO using the
// decoded HI/LO write enables and ALU_function from the control unit, and
// exposes HI/LO so the ALU result path can serve MFHI/MFLO.
//
// Multiplies use a shift-add loop on a 2*WIDTH accumulator. Divides use a
// restoring algorithm that produces one quotient bit per cycle. Both loops
// run on magnitudes, and the sign is fixed up in a single WRITE cycle.
//
// Ports:
//   clk                - rising-edge clock
//   reset              - asynchronous, active-high reset
//   instr_valid        - instruction in this stage is real (not a bubble)
//   ALU_function [5:0] - decoded function (MULT/MULTU/DIV/DIVU/MTHI/MTLO)
//   HI_register_write  - HI write enable from the control unit
//   LO_register_write  - LO write enable from the control unit
//   operand_a    [W]   - rs: multiplicand / dividend / MTHI-MTLO source
//   operand_b    [W]   - rt: multiplier / divisor
//   HI, LO       [W]   - current architectural HI and LO registers
//   busy               - operation in flight, upstream must stall
//   done               - one-cycle pulse after a mult/div writes HI/LO
// ============================================================================
module hi_lo_multiply_divide_unit #(
    parameter int ITERATIONS = 32,
    parameter int WIDTH      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    input  logic [5:0]       ALU_function,
    input  logic             HI_register_write,
    input  logic             LO_register_write,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             busy,
    output logic             done
);

    localparam logic [5:0] FUNC_MULT  = 6'b011000;
    localparam logic [5:0] FUNC_MULTU = 6'b011001;
    localparam logic [5:0] FUNC_DIV   = 6'b011010;
    localparam logic [5:0] FUNC_DIVU  = 6'b011011;
    localparam logic [5:0] FUNC_MTHI  = 6'b111111;
    localparam logic [5:0] FUNC_MTLO  = 6'b111110;

    // Wide enough to count up to ITERATIONS without wrapping.
    localparam int CW = $clog2(ITERATIONS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL   = 2'd1,
        DIV   = 2'd2,
        WRITE = 2'd3
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]        counter;
    logic [2*WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     mplier;
    logic [WIDTH-1:0]     divisor;
    logic [WIDTH-1:0]     quot;
    logic [WIDTH:0]       rem;
    logic                 neg_product;
    logic                 neg_quot;
    logic                 neg_rem;
    logic                 div_zero;
    logic                 is_div;

    logic                 accept;
    logic                 do_mthi;
    logic                 do_mtlo;
    logic                 do_mul;
    logic                 do_div;
    logic                 signed_op;
    logic                 a_neg;
    logic                 b_neg;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;

    logic [2*WIDTH-1:0]   acc_step;
    logic [WIDTH+1:0]     rem_shift;
    logic [WIDTH+1:0]     trial;
    logic                 rem_ok;
    logic [WIDTH:0]       rem_next;
    logic [WIDTH-1:0]     quot_next;
    logic                 last_step;

    logic [2*WIDTH-1:0]   product_final;
    logic [WIDTH-1:0]     quot_final;
    logic [WIDTH-1:0]     rem_final;

    assign busy = (state != IDLE);

    // Instruction decode. A new operation is only taken when the unit is
    // idle and the slot carries a real instruction with a HI/LO write. For
    // signed ops the operands are converted to magnitudes here so the
    // iterative loops only ever see unsigned values; the most negative value
    // maps onto itself, which is the correct unsigned magnitude.
    always_comb begin
        accept    = (state == IDLE) && instr_valid &&
                    (HI_register_write || LO_register_write);
        do_mthi   = accept && (ALU_function == FUNC_MTHI) && HI_register_write;
        do_mtlo   = accept && (ALU_function == FUNC_MTLO) && LO_register_write;
        do_mul    = accept && ((ALU_function == FUNC_MULT) ||
                               (ALU_function == FUNC_MULTU));
        do_div    = accept && ((ALU_function == FUNC_DIV) ||
                               (ALU_function == FUNC_DIVU));
        signed_op = (ALU_function == FUNC_MULT) || (ALU_function == FUNC_DIV);
        a_neg     = signed_op && operand_a[WIDTH-1];
        b_neg     = signed_op && operand_b[WIDTH-1];
        a_mag     = a_neg ? (~operand_a + 1'b1) : operand_a;
        b_mag     = b_neg ? (~operand_b + 1'b1) : operand_b;
    end

    // One step of each iterative algorithm. The multiply adds the shifted
    // multiplicand when the current multiplier LSB is set. The divide shifts
    // the next dividend bit into the partial remainder and subtracts the
    // divisor; a borrow out of the extra top bit means the trial failed and
    // the old shifted remainder is kept.
    always_comb begin
        acc_step  = mplier[0] ? (acc + mcand) : acc;
        rem_shift = {rem, quot[WIDTH-1]};
        trial     = rem_shift - {2'b00, divisor};
        rem_ok    = ~trial[WIDTH+1];
        rem_next  = rem_ok ? trial[WIDTH:0] : rem_shift[WIDTH:0];
        quot_next = {quot[WIDTH-2:0], rem_ok};
        last_step = (counter == CW'(ITERATIONS - 1));
    end

    // Sign fix-up applied in the WRITE cycle. Negation wraps modulo the
    // register width, which is what makes the most-negative / -1 divide
    // come out as 0x80000000 with no special case.
    always_comb begin
        product_final = neg_product ? (~acc + 1'b1) : acc;
        quot_final    = neg_quot ? (~quot + 1'b1) : quot;
        rem_final     = neg_rem ? (~rem[WIDTH-1:0] + 1'b1) : rem[WIDTH-1:0];
    end

    // State register. Reset at any point abandons whatever was in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. MTHI/MTLO complete in the accept cycle and never
    // leave IDLE; mult/div run ITERATIONS steps and then spend exactly one
    // cycle in WRITE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (do_mul) begin
                    state_next = MUL;
                end else if (do_div) begin
                    state_next = DIV;
                end
            end
            MUL: begin
                if (last_step) begin
                    state_next = WRITE;
                end
            end
            DIV: begin
                if (last_step) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Iteration datapath. Operands and result signs are captured at accept;
    // the loops then advance one step per cycle while the counter tracks
    // how many steps have been taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            counter     <= '0;
            mcand       <= '0;
            acc         <= '0;
            mplier      <= '0;
            divisor     <= '0;
            quot        <= '0;
            rem         <= '0;
            neg_product <= 1'b0;
            neg_quot    <= 1'b0;
            neg_rem     <= 1'b0;
            div_zero    <= 1'b0;
            is_div      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (do_mul) begin
                        counter     <= '0;
                        mcand       <= {{WIDTH{1'b0}}, a_mag};
                        mplier      <= b_mag;
                        acc         <= '0;
                        neg_product <= a_neg ^ b_neg;
                        is_div      <= 1'b0;
                    end else if (do_div) begin
                        counter     <= '0;
                        quot        <= a_mag;
                        divisor     <= b_mag;
                        rem         <= '0;
                        neg_quot    <= a_neg ^ b_neg;
                        neg_rem     <= a_neg;
                        div_zero    <= (operand_b == '0);
                        is_div      <= 1'b1;
                    end
                end
                MUL: begin
                    acc     <= acc_step;
                    mcand   <= mcand << 1;
                    mplier  <= mplier >> 1;
                    counter <= counter + 1'b1;
                end
                DIV: begin
                    rem     <= rem_next;
                    quot    <= quot_next;
                    counter <= counter + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Architectural HI/LO. They only move on MTHI/MTLO at accept, on the
    // WRITE cycle of a mult/div, or on reset, so MFHI/MFLO may read them
    // safely while an operation is iterating. A divide by zero leaves both
    // untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            HI <= '0;
            LO <= '0;
        end else begin
            if (do_mthi) begin
                HI <= operand_a;
            end
            if (do_mtlo) begin
                LO <= operand_a;
            end
            if (state == WRITE) begin
                if (!is_div) begin
                    {HI, LO} <= product_final;
                end else if (!div_zero) begin
                    LO <= quot_final;
                    HI <= rem_final;
                end
            end
        end
    end

    // Completion pulse, high for the cycle after the WRITE edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done <= 1'b0;
        end else begin
            done <= (state == WRITE);
        end
    end

endmodule

// File: doc/hi_lo_multiply_divide_unit.md
Name: hi_lo_multiply_divide_unit

Overview:
- Iterative multiply/divide unit that owns the architectural HI and LO registers.
- Sits downstream of the control unit and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO using the decoded HI/LO write enables and ALU_function.
- Feeds HI/LO back to the ALU result path for MFHI/MFLO.
- Asserts busy so the pipeline/hazard logic stalls while an operation is in flight.

Parameters:
- ITERATIONS, 32, shift-add / restoring-divide steps. Must equal the operand width.
- WIDTH, 32, operand and HI/LO width.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- instr_valid  input  1  instruction in this stage is real (not bubble/flushed)
- ALU_function  input  6  decoded function: 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU, 111111 MTHI, 111110 MTLO
- HI_register_write  input  1  from control unit
- LO_register_write  input  1  from control unit
- operand_a  input  WIDTH  rs value (multiplicand/dividend; MTHI/MTLO source)
- operand_b  input  WIDTH  rt value (multiplier/divisor)
- HI  output  WIDTH  current HI register
- LO  output  WIDTH  current LO register
- busy  output  1  operation in flight; upstream must stall
- done  output  1  one-cycle pulse on the cycle after HI/LO are written by a mult/div

Behaviour:
- Reset (async, any time, including mid-operation):
  - HI=0, LO=0, state IDLE, counter=0, busy=0, done=0.
  - Any in-flight operation is discarded.
- States: IDLE, MUL, DIV, WRITE.
- busy is combinational: busy = (state != IDLE).
- Accept: in IDLE, an operation is accepted when instr_valid && (HI_register_write || LO_register_write). Otherwise nothing happens.
  - MTHI (111111, HI_register_write only): HI <= operand_a at the next edge. LO unchanged. No busy, no done.
  - MTLO (111110, LO_register_write only): LO <= operand_a at the next edge. HI unchanged. No busy, no done.
  - MULT/MULTU: latch operands, go to MUL, counter=0.
    - Signed (MULT): store magnitudes and result sign = a[31]^b[31].
    - Unsigned (MULTU): store raw operands, sign=0.
  - DIV/DIVU: latch operands, go to DIV, counter=0.
    - Signed (DIV): store magnitudes; quotient sign = a[31]^b[31]; remainder sign = a[31].
  - Any other ALU_function with a write enable set: ignored, remain IDLE.
- MUL: one shift-add step per cycle on a 64-bit accumulator. After ITERATIONS steps, go to WRITE.
- DIV: one restoring step per cycle, producing 1 quotient bit and a 33-bit partial remainder. After ITERATIONS steps, go to WRITE.
- WRITE (one cycle):
  - Apply the sign fix-up by two's complement negation, mod 2^WIDTH.
  - Multiply: {HI,LO} <= 64-bit product.
  - Divide: LO <= quotient, HI <= remainder.
  - Next state IDLE; done=1 for the following cycle.
- Latency: accept edge N, iteration edges N+1..N+32, HI/LO written at edge N+33.
  - busy is high from after edge N until edge N+33.
  - done is high for the cycle after edge N+33.
  - The next operation can be accepted at edge N+34.
- Divide by zero (operand_b==0, detected at accept):
  - Normal full latency.
  - HI and LO are left unchanged at WRITE.
  - done still pulses.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (wraps).
- Ignored while busy: all accept conditions, including MTHI/MTLO. The hazard unit guarantees a stall, so no queueing is done.
- HI/LO change only at accept (MTHI/MTLO), at WRITE, or at reset. They are stable and readable during MUL/DIV.
- instr_valid=0 suppresses acceptance even when the write enables are set (flushed slot).

Test Plan:
- Reset mid-MUL:
  - Stimulus: MULT 7×6 accepted; assert reset at cycle 10.
  - Required: HI=LO=0, busy=0 immediately; no done pulse.
- MULT signed:
  - Stimulus: a=0xFFFFFFFD (-3), b=0x00000005.
  - Required: busy for 33 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFF1; done pulse once.
- MULTU:
  - Stimulus: a=0xFFFFFFFF, b=0xFFFFFFFF.
  - Required: HI=0xFFFFFFFE, LO=0x00000001.
- DIV signed:
  - Stimulus: a=0xFFFFFFF9 (-7), b=2.
  - Required: LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- DIVU by zero after MTHI/MTLO:
  - Stimulus: MTHI 0x1234, then MTLO 0x5678, then DIVU 100/0.
  - Required: HI=0x1234 and LO=0x5678 one cycle after each MT; after 33 cycles HI/LO unchanged, done pulses.
- Busy interlock and flushed slot:
  - Stimulus: during a DIV, present MTLO 0xAAAA and a second MULT; separately present MULT with instr_valid=0 while idle.
  - Required: both requests during DIV ignored, LO = DIV result only; flushed MULT causes no busy and no HI/LO change.
